// File: rtl/lbc_lseq.sv
// Local-bus transfer sequencer: turns cbus go toggles into local-bus request bursts,
// with one-deep request queuing, timeout abort and sticky error status.
module lbc_lseq #(
  parameter int IBURST = 4,
  parameter int TMO    = 255
) (
  input  logic       SYSCLK,
  input  logic       RESET_D1_R_N,
  input  logic       LC_CGO,
  input  logic [3:0] LC_CQSEL,
  input  logic       LC_RWGO,
  input  logic       LL_RDY,
  input  logic       LL_ERR,
  output logic       LL_REQ,
  output logic       LL_WR,
  output logic [3:0] LL_SRC,
  output logic [1:0] LL_BEAT,
  output logic       LL_LAST,
  output logic       LDN_CGOACK_R,
  output logic       LL_IDLE_LR,
  output logic       LL_TMO_R,
  output logic       LL_BERR_R,
  output logic       LL_OVF_R
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [1:0] LAST_BURST = 2'(IBURST - 1);
  localparam logic [7:0] TMO_LAST   = 8'(TMO - 1);

  state_t     r_state;
  logic       r_armed;
  logic       r_cgoQ;
  logic       r_pending;
  logic       r_req;
  logic       r_wr;
  logic [3:0] r_src;
  logic [1:0] r_beat;
  logic [7:0] r_wait;
  logic       r_ack;
  logic       r_idle;
  logic       r_tmo;
  logic       r_berr;
  logic       r_ovf;

  logic       w_goEdge;
  logic       w_oneHot;
  logic [1:0] w_lastBeat;
  logic       w_last;

  // The first clock after reset only records the go level, so a high level is never an edge.
  assign w_goEdge   = r_armed & (LC_CGO ^ r_cgoQ);
  assign w_oneHot   = $onehot(LC_CQSEL);
  assign w_lastBeat = r_src[1] ? LAST_BURST : 2'd0;
  assign w_last     = (r_beat == w_lastBeat);

  always_ff @(posedge SYSCLK or negedge RESET_D1_R_N) begin
    if (!RESET_D1_R_N) begin
      r_state   <= S_IDLE;
      r_armed   <= 1'b0;
      r_cgoQ    <= 1'b0;
      r_pending <= 1'b0;
      r_req     <= 1'b0;
      r_wr      <= 1'b0;
      r_src     <= 4'd0;
      r_beat    <= 2'd0;
      r_wait    <= 8'd0;
      r_ack     <= 1'b0;
      r_idle    <= 1'b1;
      r_tmo     <= 1'b0;
      r_berr    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_cgoQ  <= LC_CGO;

      if (w_goEdge && r_state != S_IDLE) begin
        if (r_pending) r_ovf <= 1'b1;
        else           r_pending <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_goEdge || r_pending) begin
            // A fresh edge arriving while the pending request is consumed stays queued.
            r_pending <= r_pending & w_goEdge;
            r_src     <= LC_CQSEL;
            r_wr      <= LC_CQSEL[3] | (LC_CQSEL[0] & ~LC_RWGO);
            r_beat    <= 2'd0;
            r_wait    <= 8'd0;
            r_tmo     <= 1'b0;
            r_idle    <= 1'b0;
            if (w_oneHot) begin
              r_berr  <= 1'b0;
              r_req   <= 1'b1;
              r_state <= S_REQ;
            end else begin
              r_berr  <= 1'b1;
              r_ack   <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            r_idle <= 1'b1;
          end
        end

        S_REQ: begin
          if (LL_RDY) begin
            r_wait <= 8'd0;
            if (LL_ERR || w_last) begin
              r_berr  <= r_berr | LL_ERR;
              r_req   <= 1'b0;
              r_ack   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_beat <= r_beat + 2'd1;
            end
          end else if (r_wait == TMO_LAST) begin
            r_tmo   <= 1'b1;
            r_req   <= 1'b0;
            r_ack   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end

        S_DONE: begin
          r_ack   <= 1'b0;
          r_idle  <= ~(r_pending | w_goEdge);
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign LL_REQ       = r_req;
  assign LL_WR        = r_wr;
  assign LL_SRC       = r_src;
  assign LL_BEAT      = r_beat;
  assign LL_LAST      = w_last;
  assign LDN_CGOACK_R = r_ack;
  assign LL_IDLE_LR   = r_idle;
  assign LL_TMO_R     = r_tmo;
  assign LL_BERR_R    = r_berr;
  assign LL_OVF_R     = r_ovf;

endmodule
